commit_ctrl: RTL and testbench
==============================

# commit_ctrl

In-order commit sequencer between the reorder buffer (ROB) head and the architectural register file. It retires at most one ROB entry per cycle and drives the regfile commit write port (en/regnm/dt/nick). It holds stores until the load/store buffer (LSB) confirms them, and on a mispredicted branch it raises the global clear plus a fetch redirect.

## Interface
- NICK_W, 5: ROB tag width; tag 0 is reserved for "no rename".
- NAME_W, 5: architectural register index width.
- DATA_W, 32: data width.
- ADDR_W, 32: PC width.
- clk  in  1  clock; everything is on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; low freezes the block.
- iROB_head_vld  in  1  ROB head entry is complete and ready to retire.
- iROB_head_nick  in  NICK_W  tag of the head entry.
- iROB_head_kind  in  2  entry kind: 0 = WB (ALU/load/jump), 1 = STORE, 2 = BRANCH, 3 = reserved (treated as WB).
- iROB_head_rd_regnm  in  NAME_W  destination register.
- iROB_head_dt  in  DATA_W  result data.
- iROB_head_mispred  in  1  branch or jump was mispredicted.
- iROB_head_tgt_pc  in  ADDR_W  correct next PC.
- oROB_pop  out  1  combinational; the ROB advances its head at this edge.
- oRF_en  out  1  registered regfile commit write enable.
- oRF_rd_regnm  out  NAME_W  registered; write index.
- oRF_rd_dt  out  DATA_W  registered; write data.
- oRF_rd_nick  out  NICK_W  registered; retiring tag. The regfile clears the rename only if this tag matches.
- oLSB_st_go  out  1  registered level; permits the LSB to perform the head store.
- iLSB_st_done  in  1  one-cycle pulse; the store has been written to memory.
- oCLR  out  1  registered one-cycle global flush pulse.
- oIF_jump_en  out  1  registered one-cycle fetch redirect.
- oIF_jump_pc  out  ADDR_W  registered redirect target.
- oCommit_cnt  out  32  number of retired instructions; wraps modulo 2^32.

## Operation
- States: RUN, ST_WAIT, FLUSH. Reset state is RUN.
- Behaviour in RUN, when rdy=1 and iROB_head_vld=1:
  - WB: oROB_pop=1. Next edge sets oRF_en = (rd≠0) and latches regnm/dt/nick. Stay in RUN.
  - BRANCH, mispred=0: oROB_pop=1. oRF_en=0 next cycle. Stay in RUN.
  - BRANCH, mispred=1: oROB_pop=1. Next cycle: oRF_en = (rd≠0) with that entry's fields, oCLR=1, oIF_jump_en=1, oIF_jump_pc = tgt_pc. Go to FLUSH.
  - STORE: oROB_pop=0. Next edge sets oLSB_st_go=1. Go to ST_WAIT.
- ST_WAIT:
  - Hold oLSB_st_go=1 and ignore the head fields.
  - When rdy=1 and iLSB_st_done=1: oROB_pop=1 combinationally; next edge clears oLSB_st_go and returns to RUN.
  - Stores never assert oRF_en.
- FLUSH: lasts exactly one cycle. oROB_pop=0 and head_vld is ignored while the ROB empties. Then RUN.
- oROB_pop = rdy & ((RUN & head_vld & kind≠STORE) | (ST_WAIT & iLSB_st_done)).
- oCommit_cnt increments by 1 on every edge where oROB_pop=1.
- oRF_en, oCLR and oIF_jump_en are single-cycle. They drop to 0 on any edge without a new qualifying commit.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - every output to 0 (oRF_* fields, oCLR, oIF_jump_*, oLSB_st_go, oCommit_cnt);
  - state to RUN.
- Reset asserted during ST_WAIT drops oLSB_st_go immediately. No pop occurs.
- Throughput is one retire per cycle for WB and correctly predicted branches. A regfile write appears 1 cycle after its pop edge.
- A store costs at least 2 cycles: the go cycle plus the done cycle. If done arrives in the first go-high cycle, the pop happens that same cycle.
- rdy=0:
  - oROB_pop=0;
  - state, oLSB_st_go and oCommit_cnt hold;
  - pulse outputs go to 0 at the next edge;
  - iLSB_st_done is ignored.
- A mispredicted-branch write and oCLR share the same cycle. The regfile writes data and zeros all nicks together.
- Counter wrap: 0xFFFFFFFF + 1 → 0.

## Test plan
- Reset: hold rst_n=0 mid-cycle → all outputs 0 asynchronously; after release with head_vld=0, no pop and counter = 0.
- Back-to-back WB: 3 heads (rd=5, dt=0x11, nick=1; rd=6, 0x22, 2; rd=0, 0x33, 3) → pop high for 3 consecutive cycles; oRF_en = 1, 1, 0 one cycle later with matching fields; counter = 3.
- Store handshake: STORE head, iLSB_st_done pulsed 4 cycles after go → oLSB_st_go high for exactly those cycles; single pop on the done cycle; oRF_en never asserted; counter +1.
- Mispredict: BRANCH rd=1, dt=0x1004, mispred=1, tgt_pc=0x2000 → next cycle oRF_en=1, oRF_rd_regnm=1, oCLR=1, oIF_jump_en=1, oIF_jump_pc=0x2000; following cycle no pop despite head_vld=1; normal retire resumes after that.
- rdy stall: drop rdy during ST_WAIT with done pulsed → no pop, go held; raise rdy and pulse done → pop; counter +1 only once.
- Wrap: preload the counter to 0xFFFFFFFF via 2^32−1 commits (or a forced value) and commit one WB → counter = 0.

Source files
------------

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order ROB-head retire sequencer driving the regfile commit port, store handshake and mispredict flush
module commit_ctrl #(
    parameter int NICK_W = 5,
    parameter int NAME_W = 5,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              iROB_head_vld,
    input  logic [NICK_W-1:0] iROB_head_nick,
    input  logic [1:0]        iROB_head_kind,
    input  logic [NAME_W-1:0] iROB_head_rd_regnm,
    input  logic [DATA_W-1:0] iROB_head_dt,
    input  logic              iROB_head_mispred,
    input  logic [ADDR_W-1:0] iROB_head_tgt_pc,
    output logic              oROB_pop,
    output logic              oRF_en,
    output logic [NAME_W-1:0] oRF_rd_regnm,
    output logic [DATA_W-1:0] oRF_rd_dt,
    output logic [NICK_W-1:0] oRF_rd_nick,
    output logic              oLSB_st_go,
    input  logic              iLSB_st_done,
    output logic              oCLR,
    output logic              oIF_jump_en,
    output logic [ADDR_W-1:0] oIF_jump_pc,
    output logic [31:0]       oCommit_cnt
);
    typedef enum logic [1:0] {RUN, ST_WAIT, FLUSH} state_t;
    state_t state;
    logic run_take, is_st, is_br, wr, flush;
    assign run_take = rdy & (state == RUN) & iROB_head_vld;
    assign is_st    = iROB_head_kind == 2'd1;
    assign is_br    = iROB_head_kind == 2'd2;
    assign wr       = run_take & ~is_st & (~is_br | iROB_head_mispred);
    assign flush    = run_take & is_br & iROB_head_mispred;
    assign oROB_pop = (run_take & ~is_st) | (rdy & (state == ST_WAIT) & iLSB_st_done);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            oRF_en       <= 1'b0;
            oRF_rd_regnm <= '0;
            oRF_rd_dt    <= '0;
            oRF_rd_nick  <= '0;
            oLSB_st_go   <= 1'b0;
            oCLR         <= 1'b0;
            oIF_jump_en  <= 1'b0;
            oIF_jump_pc  <= '0;
            oCommit_cnt  <= '0;
        end else begin
            oRF_en      <= wr & (|iROB_head_rd_regnm);
            oCLR        <= flush;
            oIF_jump_en <= flush;
            if (wr) begin
                oRF_rd_regnm <= iROB_head_rd_regnm;
                oRF_rd_dt    <= iROB_head_dt;
                oRF_rd_nick  <= iROB_head_nick;
            end
            if (flush) oIF_jump_pc <= iROB_head_tgt_pc;
            if (oROB_pop) oCommit_cnt <= oCommit_cnt + 32'd1;
            if (rdy) begin
                unique case (state)
                    RUN: begin
                        if (iROB_head_vld & is_st) begin
                            oLSB_st_go <= 1'b1;
                            state      <= ST_WAIT;
                        end else if (flush) begin
                            state <= FLUSH;
                        end
                    end
                    ST_WAIT: begin
                        if (iLSB_st_done) begin
                            oLSB_st_go <= 1'b0;
                            state      <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed self-checking bench for commit_ctrl
module tb_commit_ctrl;
    logic        clk, rst_n, rdy, vld, mis, done;
    logic [4:0]  nick, rd;
    logic [1:0]  kind;
    logic [31:0] dt, tgt;
    logic        pop, rf_en, st_go, clr, jump_en;
    logic [4:0]  rf_regnm, rf_nick;
    logic [31:0] rf_dt, jump_pc, cnt;
    int checks = 0;
    int failures = 0;

    commit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .iROB_head_vld(vld), .iROB_head_nick(nick), .iROB_head_kind(kind),
        .iROB_head_rd_regnm(rd), .iROB_head_dt(dt), .iROB_head_mispred(mis),
        .iROB_head_tgt_pc(tgt), .oROB_pop(pop), .oRF_en(rf_en),
        .oRF_rd_regnm(rf_regnm), .oRF_rd_dt(rf_dt), .oRF_rd_nick(rf_nick),
        .oLSB_st_go(st_go), .iLSB_st_done(done), .oCLR(clr),
        .oIF_jump_en(jump_en), .oIF_jump_pc(jump_pc), .oCommit_cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic head(input logic v, input logic [1:0] k, input logic [4:0] r,
                        input logic [31:0] d, input logic m, input logic [31:0] t,
                        input logic [4:0] n);
        vld = v; kind = k; rd = r; dt = d; mis = m; tgt = t; nick = n;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; done = 1'b0;
        head(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_rf_en", {31'b0, rf_en}, 0);
        chk("rst_st_go", {31'b0, st_go}, 0);
        chk("rst_clr", {31'b0, clr}, 0);
        chk("rst_jump", {31'b0, jump_en}, 0);
        chk("rst_jump_pc", jump_pc, 0);
        chk("rst_cnt", cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle_pop", {31'b0, pop}, 0);
        chk("idle_cnt", cnt, 0);
        // back-to-back WB retires
        head(1, 0, 5, 32'h11, 0, 0, 1);
        chk("wb1_pop", {31'b0, pop}, 1);
        tick();
        chk("wb1_en", {31'b0, rf_en}, 1);
        chk("wb1_regnm", {27'b0, rf_regnm}, 5);
        chk("wb1_dt", rf_dt, 32'h11);
        chk("wb1_nick", {27'b0, rf_nick}, 1);
        head(1, 0, 6, 32'h22, 0, 0, 2);
        chk("wb2_pop", {31'b0, pop}, 1);
        tick();
        chk("wb2_en", {31'b0, rf_en}, 1);
        chk("wb2_regnm", {27'b0, rf_regnm}, 6);
        chk("wb2_dt", rf_dt, 32'h22);
        chk("wb2_nick", {27'b0, rf_nick}, 2);
        head(1, 0, 0, 32'h33, 0, 0, 3);
        chk("wb3_pop", {31'b0, pop}, 1);
        tick();
        chk("wb3_en", {31'b0, rf_en}, 0);
        chk("wb3_cnt", cnt, 3);
        head(0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wb_drop_en", {31'b0, rf_en}, 0);
        // store handshake, done on the 4th go-high cycle
        head(1, 1, 7, 32'h77, 0, 0, 4);
        chk("st_req_pop", {31'b0, pop}, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st_wait_go", {31'b0, st_go}, 1);
            chk("st_wait_pop", {31'b0, pop}, 0);
            chk("st_wait_en", {31'b0, rf_en}, 0);
            tick();
        end
        chk("st_done_go", {31'b0, st_go}, 1);
        done = 1'b1;
        head(0, 0, 0, 0, 0, 0, 0);
        chk("st_done_pop", {31'b0, pop}, 1);
        tick();
        done = 1'b0;
        chk("st_end_go", {31'b0, st_go}, 0);
        chk("st_end_en", {31'b0, rf_en}, 0);
        chk("st_cnt", cnt, 4);
        // mispredicted branch, then a head that must wait out the flush cycle
        head(1, 2, 1, 32'h1004, 1, 32'h2000, 5);
        chk("mp_pop", {31'b0, pop}, 1);
        tick();
        chk("mp_en", {31'b0, rf_en}, 1);
        chk("mp_regnm", {27'b0, rf_regnm}, 1);
        chk("mp_dt", rf_dt, 32'h1004);
        chk("mp_clr", {31'b0, clr}, 1);
        chk("mp_jump", {31'b0, jump_en}, 1);
        chk("mp_jump_pc", jump_pc, 32'h2000);
        chk("mp_cnt", cnt, 5);
        head(1, 0, 9, 32'h99, 0, 0, 6);
        chk("flush_pop", {31'b0, pop}, 0);
        tick();
        chk("flush_clr", {31'b0, clr}, 0);
        chk("flush_jump", {31'b0, jump_en}, 0);
        chk("flush_en", {31'b0, rf_en}, 0);
        chk("flush_cnt", cnt, 5);
        chk("resume_pop", {31'b0, pop}, 1);
        tick();
        chk("resume_en", {31'b0, rf_en}, 1);
        chk("resume_regnm", {27'b0, rf_regnm}, 9);
        chk("resume_cnt", cnt, 6);
        // correctly predicted branch
        head(1, 2, 3, 32'h44, 0, 32'h3000, 7);
        chk("br_pop", {31'b0, pop}, 1);
        tick();
        chk("br_en", {31'b0, rf_en}, 0);
        chk("br_clr", {31'b0, clr}, 0);
        chk("br_cnt", cnt, 7);
        // rdy stall during ST_WAIT
        head(1, 1, 0, 0, 0, 0, 8);
        tick();
        head(0, 0, 0, 0, 0, 0, 0);
        rdy = 1'b0; done = 1'b1;
        #1;
        chk("stall_pop", {31'b0, pop}, 0);
        tick();
        chk("stall_go", {31'b0, st_go}, 1);
        chk("stall_cnt", cnt, 7);
        rdy = 1'b1; done = 1'b0;
        tick();
        chk("unstall_go", {31'b0, st_go}, 1);
        done = 1'b1;
        #1;
        chk("unstall_pop", {31'b0, pop}, 1);
        tick();
        done = 1'b0;
        chk("unstall_go_clr", {31'b0, st_go}, 0);
        chk("unstall_cnt", cnt, 8);
        // rdy low in RUN
        rdy = 1'b0;
        head(1, 0, 4, 32'h55, 0, 0, 9);
        chk("rdy0_pop", {31'b0, pop}, 0);
        tick();
        chk("rdy0_en", {31'b0, rf_en}, 0);
        chk("rdy0_cnt", cnt, 8);
        rdy = 1'b1;
        head(0, 0, 0, 0, 0, 0, 0);
        // async reset in ST_WAIT
        head(1, 1, 0, 0, 0, 0, 10);
        tick();
        head(0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_go", {31'b0, st_go}, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_go", {31'b0, st_go}, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_en", {31'b0, rf_en}, 0);
        @(negedge clk) rst_n = 1'b1;
        done = 1'b1;
        #1;
        chk("post_rst_pop", {31'b0, pop}, 0);
        tick();
        done = 1'b0;
        chk("post_rst_go", {31'b0, st_go}, 0);
        chk("post_rst_cnt", cnt, 0);
        // counter wrap
        @(negedge clk);
        force dut.oCommit_cnt = 32'hFFFF_FFFF;
        #1 release dut.oCommit_cnt;
        #1;
        chk("preload_cnt", cnt, 32'hFFFF_FFFF);
        head(1, 0, 2, 32'hAB, 0, 0, 11);
        tick();
        chk("wrap_cnt", cnt, 0);
        chk("wrap_en", {31'b0, rf_en}, 1);
        head(0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
